led_status_sequencer: RTL and testbench

//  Drives the card's three status LEDs from a shared tick timebase:

---
 rtl/led_status_sequencer_if.sv | 27 ++
 rtl/led_status_sequencer.sv | 178 +++++++++++++++++
 tb/tb_led_status_sequencer.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/led_status_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : led_status_sequencer_if
//  Brief    : Error-code handshake between an error source and the LED sequencer.
//  Revision : 1.0  initial release
// ============================================================================
interface led_status_sequencer_if;
    logic       err_valid;
    logic [3:0] err_code;
    logic       err_ready;
    logic       err_busy;

    modport master (
        output err_valid,
        output err_code,
        input  err_ready,
        input  err_busy
    );

    modport slave (
        input  err_valid,
        input  err_code,
        output err_ready,
        output err_busy
    );
endinterface
`default_nettype wire

// File: rtl/led_status_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : led_status_sequencer
//  Brief    : Three status LEDs: heartbeat, config state, SDRAM activity with
//             blink-coded error reports. Define LED_ERR_REPEAT_EN to repeat codes.
//  Revision : 1.0  initial release
// ============================================================================
module led_status_sequencer #(
    parameter int PRESCALE    = 1048576,
    parameter int HB_TICKS    = 16,
    parameter int ACT_TICKS   = 4,
    parameter int BLINK_TICKS = 8,
    parameter int GAP_TICKS   = 32
) (
    input  wire logic             clk,
    input  wire logic             reset_n,
    input  wire logic             shutup,
    input  wire logic             configured,
    input  wire logic             unconfigured,
    input  wire logic             sdram_access,
    led_status_sequencer_if.slave err,
    output logic [2:0]            LED
);
    localparam int c_pre_w  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int c_hb_w   = (HB_TICKS > 1) ? $clog2(HB_TICKS) : 1;
    localparam int c_act_w  = $clog2(ACT_TICKS + 1);
    localparam int c_ph_max = (BLINK_TICKS > GAP_TICKS) ? BLINK_TICKS : GAP_TICKS;
    localparam int c_ph_w   = (c_ph_max > 1) ? $clog2(c_ph_max) : 1;

    localparam logic [c_pre_w-1:0] c_pre_last   = c_pre_w'(PRESCALE - 1);
    localparam logic [c_hb_w-1:0]  c_hb_last    = c_hb_w'(HB_TICKS - 1);
    localparam logic [c_act_w-1:0] c_act_load   = c_act_w'(ACT_TICKS);
    localparam logic [c_ph_w-1:0]  c_blink_last = c_ph_w'(BLINK_TICKS - 1);
    localparam logic [c_ph_w-1:0]  c_gap_last   = c_ph_w'(GAP_TICKS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_OFF  = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    logic [c_pre_w-1:0] r_pre;
    logic [c_hb_w-1:0]  r_hb_cnt;
    logic               r_hb;
    logic [c_act_w-1:0] r_act_cnt;
    logic [c_ph_w-1:0]  r_ph_cnt;
    logic [3:0]         r_remain;
    state_t             r_state;
    logic               r_led0;
    logic               r_led1;
    logic               r_led2;

    logic               w_tick;
    logic               w_act;
    logic               w_accept;
    logic [c_ph_w-1:0]  w_ph_last;
    logic               w_unused_unconfigured;

    // unconfigured carries no information beyond !configured & !shutup
    assign w_unused_unconfigured = unconfigured;

    assign w_tick    = (r_pre == c_pre_last);
    assign w_act     = (r_act_cnt != '0);
    assign w_accept  = err.err_valid & err.err_ready;
    assign w_ph_last = (r_state == S_GAP) ? c_gap_last : c_blink_last;

`ifdef LED_ERR_REPEAT_EN
    assign err.err_ready = (r_state == S_IDLE) || (r_state == S_GAP);
`else
    assign err.err_ready = (r_state == S_IDLE);
`endif
    assign err.err_busy  = (r_state != S_IDLE);

    assign LED = {r_led2, r_led1, r_led0};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pre <= '0;
        end else if (w_tick) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + c_pre_w'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hb_cnt <= '0;
            r_hb     <= 1'b0;
        end else if (w_tick) begin
            if (r_hb_cnt == c_hb_last) begin
                r_hb_cnt <= '0;
                r_hb     <= ~r_hb;
            end else begin
                r_hb_cnt <= r_hb_cnt + c_hb_w'(1);
            end
        end
    end

    // A fresh access always reloads, even on a tick cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_act_cnt <= '0;
        end else if (sdram_access) begin
            r_act_cnt <= c_act_load;
        end else if (w_tick && w_act) begin
            r_act_cnt <= r_act_cnt - c_act_w'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_led0 <= 1'b0;
            r_led1 <= 1'b0;
        end else begin
            r_led0 <= r_hb;
            r_led1 <= shutup ? 1'b1 : (configured ? 1'b0 : r_hb);
        end
    end

`ifdef LED_ERR_REPEAT_EN
    logic [3:0] r_code;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_code <= 4'd0;
        end else if (w_accept) begin
            r_code <= err.err_code;
        end
    end
`endif

    // Blink-code FSM; the phase counter restarts on every state entry so the
    // tick coinciding with entry never counts toward the new phase.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_ph_cnt <= '0;
            r_remain <= 4'd0;
            r_led2   <= 1'b0;
        end else begin
            r_led2 <= (r_state == S_IDLE) ? w_act : (r_state == S_ON);
            if (w_accept) begin
                r_remain <= err.err_code;
                r_ph_cnt <= '0;
                r_state  <= (err.err_code != 4'd0) ? S_ON : S_GAP;
            end else if (w_tick && (r_state != S_IDLE)) begin
                if (r_ph_cnt == w_ph_last) begin
                    r_ph_cnt <= '0;
                    case (r_state)
                        S_ON: begin
                            r_state <= S_OFF;
                        end
                        S_OFF: begin
                            r_remain <= r_remain - 4'd1;
                            r_state  <= (r_remain != 4'd1) ? S_ON : S_GAP;
                        end
                        S_GAP: begin
`ifdef LED_ERR_REPEAT_EN
                            r_remain <= r_code;
                            r_state  <= (r_code != 4'd0) ? S_ON : S_GAP;
`else
                            r_state  <= S_IDLE;
`endif
                        end
                        default: begin
                            r_state <= S_IDLE;
                        end
                    endcase
                end else begin
                    r_ph_cnt <= r_ph_cnt + c_ph_w'(1);
                end
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_led_status_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_led_status_sequencer
//  Brief    : Self-checking bench; reference model derives LED/handshake state
//             from elapsed ticks since the last access / accepted code.
//  Revision : 1.0  initial release
// ============================================================================
module tb_led_status_sequencer;
    localparam int P   = 4;
    localparam int HB  = 2;
    localparam int ACT = 3;
    localparam int BL  = 2;
    localparam int GP  = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       shutup = 1'b0;
    logic       configured = 1'b0;
    logic       unconfigured = 1'b1;
    logic       sdram_access = 1'b0;
    logic [2:0] led;

    led_status_sequencer_if err_if();

    led_status_sequencer #(
        .PRESCALE    (P),
        .HB_TICKS    (HB),
        .ACT_TICKS   (ACT),
        .BLINK_TICKS (BL),
        .GAP_TICKS   (GP)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .shutup       (shutup),
        .configured   (configured),
        .unconfigured (unconfigured),
        .sdram_access (sdram_access),
        .err          (err_if),
        .LED          (led)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    // State is a pure function of edge count n: ticks fall on edges n%P==0.
    int         m_n;
    bit         m_has_acc;
    int         m_a;
    bit         m_has_code;
    int         m_s;
    int         m_c;
    logic [2:0] m_led;

    function automatic bit hb_at(input int k);
        return ((k / (P * HB)) % 2) == 1;
    endfunction

    function automatic bit act_at(input int k);
        return m_has_acc && ((k / P - m_a / P) < ACT);
    endfunction

    // 0 idle, 1 on, 2 off, 3 gap
    function automatic int st_at(input int k);
        int kk;
        int total;
        if (!m_has_code) return 0;
        kk    = k / P - m_s / P;
        total = 2 * BL * m_c + GP;
`ifdef LED_ERR_REPEAT_EN
        kk = kk % total;
`else
        if (kk >= total) return 0;
`endif
        if (kk < 2 * BL * m_c) return ((kk / BL) % 2 == 0) ? 1 : 2;
        return 3;
    endfunction

    function automatic bit ready_of(input int st);
`ifdef LED_ERR_REPEAT_EN
        return (st == 0) || (st == 3);
`else
        return st == 0;
`endif
    endfunction

    initial begin
        forever begin : model_step
            int prev_st;
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                m_n = 0; m_has_acc = 0; m_a = 0; m_has_code = 0; m_s = 0; m_c = 0;
                m_led = 3'b000;
            end else begin
                prev_st  = st_at(m_n);
                m_led[0] = hb_at(m_n);
                m_led[1] = shutup ? 1'b1 : (configured ? 1'b0 : hb_at(m_n));
                m_led[2] = (prev_st == 0) ? act_at(m_n) : (prev_st == 1);
                m_n++;
                if (sdram_access) begin
                    m_has_acc = 1; m_a = m_n;
                end
                if (err_if.err_valid && ready_of(prev_st)) begin
                    m_has_code = 1; m_s = m_n; m_c = int'(err_if.err_code);
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (reset_n) begin
                check("led", led, m_led);
                check("err_ready", err_if.err_ready, ready_of(st_at(m_n)));
                check("err_busy", err_if.err_busy, st_at(m_n) != 0);
            end
        end
    end

    // ---------------- directed + random stimulus ----------------
    int  len, pulses, bad_len, run, cyc, w;
    bit  prev, prev_ready, busy_dropped;

    task automatic send_code(input int code);
        int wt;
        wt = 0;
        err_if.err_valid = 1'b1;
        err_if.err_code  = 4'(code);
        while (err_if.err_ready !== 1'b1 && wt < 100) begin
            @(negedge clk);
            wt++;
        end
        if (wt >= 100) check("handshake_ready", err_if.err_ready, 1);
        @(negedge clk);
        err_if.err_valid = 1'b0;
    endtask

    task automatic reset_mid_run();
        #2 reset_n = 1'b0;
        #1;
        check("rst_led", led, 3'b000);
        check("rst_busy", err_if.err_busy, 0);
        check("rst_ready", err_if.err_ready, 1);
        err_if.err_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        err_if.err_valid = 1'b0;
        err_if.err_code  = 4'd0;
        repeat (3) @(negedge clk);
        check("reset_led", led, 3'b000);
        check("reset_ready", err_if.err_ready, 1);
        check("reset_busy", err_if.err_busy, 0);
        reset_n = 1'b1;

        // heartbeat: rises after edge 9, falls after edge 17
        repeat (8) @(negedge clk);
        check("hb_before_rise", led[0], 0);
        @(negedge clk);
        check("hb_rise", led[0], 1);
        check("led1_follows_hb", led[1], 1);
        repeat (7) @(negedge clk);
        check("hb_still_high", led[0], 1);
        @(negedge clk);
        check("hb_fall", led[0], 0);

        configured = 1'b1;
        @(negedge clk);
        check("configured_led1", led[1], 0);
        shutup = 1'b1;
        @(negedge clk);
        check("both_flags_led1", led[1], 1);
        configured = 1'b0;
        @(negedge clk);
        check("shutup_led1", led[1], 1);
        shutup = 1'b0;

        // single access
        sdram_access = 1'b1;
        @(negedge clk);
        sdram_access = 1'b0;
        check("act_not_yet", led[2], 0);
        @(negedge clk);
        check("act_led2_on", led[2], 1);
        len = 0;
        while (led[2] === 1'b1 && len < 40) begin
            len++;
            @(negedge clk);
        end
        check("act_hold_9_to_12", (len >= 9 && len <= 12), 1);

        // retrigger six clocks later
        sdram_access = 1'b1;
        @(negedge clk);
        sdram_access = 1'b0;
        repeat (5) @(negedge clk);
        sdram_access = 1'b1;
        @(negedge clk);
        sdram_access = 1'b0;
        len = 0;
        while (led[2] === 1'b1 && len < 40) begin
            len++;
            @(negedge clk);
        end
        check("act_retrigger_10_to_13", (len >= 10 && len <= 13), 1);
        repeat (3) @(negedge clk);

`ifdef LED_ERR_REPEAT_EN
        // code 2 repeats without returning to IDLE
        send_code(2);
        pulses = 0; prev = 0; cyc = 0; busy_dropped = 0;
        while (pulses < 5 && cyc < 300) begin
            if (led[2] && !prev) pulses++;
            if (err_if.err_busy !== 1'b1) busy_dropped = 1;
            prev = led[2];
            cyc++;
            @(negedge clk);
        end
        check("repeat_pulses", pulses, 5);
        check("repeat_no_idle", busy_dropped, 0);
        reset_mid_run();
`else
        // code 3: three pulses, then gap
        send_code(3);
        pulses = 0; bad_len = 0; run = 0; prev = 0; cyc = 0;
        while (err_if.err_busy === 1'b1 && cyc < 400) begin
            if (led[2]) run++;
            else if (prev) begin
                pulses++;
                if (run < 5 || run > 8) bad_len++;
                run = 0;
            end
            prev = led[2];
            cyc++;
            @(negedge clk);
        end
        check("code3_pulses", pulses, 3);
        check("code3_pulse_len_bad", bad_len, 0);
        check("code3_busy_61_to_64", (cyc >= 61 && cyc <= 64), 1);
        check("code3_ready_after", err_if.err_ready, 1);

        // code 0: gap only, with a held request waiting behind it
        send_code(0);
        err_if.err_valid = 1'b1;
        err_if.err_code  = 4'd2;
        cyc = 0; bad_len = 0;
        while (err_if.err_busy === 1'b1 && cyc < 100) begin
            if (led[2] !== 1'b0) bad_len++;
            cyc++;
            @(negedge clk);
        end
        check("code0_busy_13_to_16", (cyc >= 13 && cyc <= 16), 1);
        check("code0_no_blink", bad_len, 0);
        check("held_ready_idle", err_if.err_ready, 1);
        @(negedge clk);
        check("held_accepted_first_idle", err_if.err_busy, 1);
        err_if.err_valid = 1'b0;

        // reset during the second ON phase
        pulses = 0; prev = 0; cyc = 0;
        while (pulses < 2 && cyc < 100) begin
            @(negedge clk);
            if (led[2] && !prev) pulses++;
            prev = led[2];
            cyc++;
        end
        check("second_on_reached", pulses, 2);
        reset_mid_run();
`endif

        // randomized traffic
        prev_ready = 0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (i == 1700) begin
                reset_mid_run();
                prev_ready = 0;
                continue;
            end
            if (err_if.err_valid && prev_ready) err_if.err_valid = 1'b0;
            else if (err_if.err_valid && $urandom_range(0, 199) == 0) err_if.err_valid = 1'b0;
            sdram_access = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 63) == 0) configured = ~configured;
            if ($urandom_range(0, 63) == 0) shutup = ~shutup;
            if ($urandom_range(0, 31) == 0) unconfigured = ~unconfigured;
            if (!err_if.err_valid && $urandom_range(0, 39) == 0) begin
                err_if.err_valid = 1'b1;
                err_if.err_code  = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15))
                                                               : 4'($urandom_range(0, 4));
            end
            prev_ready = err_if.err_ready;
        end
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d passed=%0d", n_checks, n_pass);
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
